// File: rtl/br_rob_id_mbuf_if.sv
// Bus bundle for br_rob_id_mbuf. Carries the allocate, retire, lookup and flush inputs
// together with the index and status outputs; the master drives the requests.
`ifndef RobDepth
`define RobDepth 64
`endif

interface br_rob_id_mbuf_if #(
  parameter int ROB_DEPTH = `RobDepth,
  parameter int DEPTH     = 16,
  parameter int WNUM      = 2,
  parameter int RNUM      = 2,
  parameter int ENUM      = 2
);
  localparam int ROB  = $clog2(ROB_DEPTH);
  localparam int ADDR = $clog2(DEPTH);
  localparam int CNT  = $clog2(DEPTH + 1);

  logic [WNUM-1:0]           we_;
  logic [WNUM-1:0][ROB-1:0]  wd;
  logic [RNUM-1:0]           re_;
  logic [RNUM-1:0][ADDR-1:0] ridx;
  logic [ENUM-1:0][ROB-1:0]  exe_rob_id;
  logic [ENUM-1:0]           exe_hit_;
  logic [ENUM-1:0][ADDR-1:0] exe_idx;
  logic [ROB-1:0]            wb_rob_id;
  logic                      wb_flush_;
  logic                      wb_match_;
  logic [ADDR-1:0]           wb_idx;
  logic [CNT-1:0]            count;
  logic                      full_;
  logic                      empty_;
  logic                      ovf_;

  modport master (
    output we_, wd, re_, exe_rob_id, wb_rob_id, wb_flush_,
    input  ridx, exe_hit_, exe_idx, wb_match_, wb_idx, count, full_, empty_, ovf_
  );

  modport slave (
    input  we_, wd, re_, exe_rob_id, wb_rob_id, wb_flush_,
    output ridx, exe_hit_, exe_idx, wb_match_, wb_idx, count, full_, empty_, ovf_
  );
endinterface

// File: rtl/br_rob_id_mbuf.sv
// Program-order ring of in-flight branch ROB IDs. Lookups are combinational on the current state, updates land one cycle later.
// There is no stall: writes or retires beyond capacity/occupancy are dropped and flagged on ovf_ the next cycle.
`ifndef RobDepth
`define RobDepth 64
`endif

module br_rob_id_mbuf #(
  parameter int ROB_DEPTH = `RobDepth,
  parameter int DEPTH     = 16,
  parameter int WNUM      = 2,
  parameter int RNUM      = 2,
  parameter int ENUM      = 2
) (
  input logic             clk,
  input logic             reset,
  br_rob_id_mbuf_if.slave bus
);
  localparam int ROB  = $clog2(ROB_DEPTH);
  localparam int ADDR = $clog2(DEPTH);
  localparam int CNT  = $clog2(DEPTH + 1);
  localparam int SW   = CNT + 1;
  localparam int NK   = ENUM + 1;

  logic [ROB-1:0]  data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [ADDR-1:0] head, tail;
  logic [CNT-1:0]  count;
  logic            ovf_q;

  logic [NK-1:0][ROB-1:0]  key;
  logic [NK-1:0]           hit;
  logic [NK-1:0][ADDR-1:0] hidx;

  // Scan youngest to oldest so the oldest match is the last one written.
  always_comb begin
    key  = '0;
    hit  = '0;
    hidx = '0;
    for (int k = 0; k < ENUM; k++) key[k] = bus.exe_rob_id[k];
    key[ENUM] = bus.wb_rob_id;
    for (int k = 0; k < NK; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (valid[tail + ADDR'(i)] && data[tail + ADDR'(i)] == key[k]) begin
          hit[k]  = 1'b1;
          hidx[k] = tail + ADDR'(i);
        end
      end
    end
  end

  always_comb begin
    bus.ridx = '0;
    for (int r = 0; r < RNUM; r++) bus.ridx[r] = tail + ADDR'(r);
  end

  assign bus.exe_hit_  = ~hit[ENUM-1:0];
  assign bus.exe_idx   = hidx[ENUM-1:0];
  assign bus.wb_match_ = ~hit[ENUM];
  assign bus.wb_idx    = hidx[ENUM];
  assign bus.count     = count;
  assign bus.full_     = ~(count == CNT'(DEPTH));
  assign bus.empty_    = ~(count == '0);
  assign bus.ovf_      = ovf_q;

  logic [SW-1:0]   nr_req, nw_req, nr, nw, space, cnt_w, dist_wb;
  logic [ADDR-1:0] d_wb, di;
  logic            run, fl, ovf_d;
  logic [DEPTH-1:0] retire_m, flush_m, wr_m;
  logic [DEPTH-1:0][ROB-1:0] wr_dat;

  always_comb begin
    nr_req = '0;
    for (int r = 0; r < RNUM; r++)
      if (!bus.re_[r]) nr_req = nr_req + SW'(1);
    nw_req = '0;
    run    = 1'b1;
    for (int w = 0; w < WNUM; w++) begin
      run = run & ~bus.we_[w];
      if (run) nw_req = nw_req + SW'(1);
    end

    cnt_w   = SW'(count);
    nr      = (nr_req > cnt_w) ? cnt_w : nr_req;
    fl      = !bus.wb_flush_ && hit[ENUM];
    d_wb    = hidx[ENUM] - tail;
    dist_wb = SW'(d_wb);
    // Anything past the flushed branch is discarded anyway; never let tail overtake wb_idx+1.
    if (fl && nr > dist_wb + SW'(1)) nr = dist_wb + SW'(1);
    space = SW'(DEPTH) - cnt_w + nr;
    nw    = fl ? '0 : ((nw_req > space) ? space : nw_req);
    ovf_d = (nr_req > cnt_w) || (!fl && nw_req > space);

    di       = '0;
    retire_m = '0;
    flush_m  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      di          = ADDR'(i) - tail;
      retire_m[i] = SW'(di) < nr;
      flush_m[i]  = fl && (SW'(di) > dist_wb);
    end

    wr_m   = '0;
    wr_dat = '0;
    for (int w = 0; w < WNUM; w++) begin
      if (SW'(w) < nw) begin
        wr_m[head + ADDR'(w)]   = 1'b1;
        wr_dat[head + ADDR'(w)] = bus.wd[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf_q <= 1'b1;
    end else begin
      // A write into a slot retiring this cycle (full buffer) must win.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_m[i]) begin
          valid[i] <= 1'b1;
          data[i]  <= wr_dat[i];
        end else if (retire_m[i]) begin
          valid[i] <= 1'b0;
          data[i]  <= '0;
        end else if (flush_m[i]) begin
          valid[i] <= 1'b0;
        end
      end
      head  <= fl ? hidx[ENUM] + ADDR'(1) : head + ADDR'(nw);
      tail  <= tail + ADDR'(nr);
      count <= fl ? CNT'(dist_wb + SW'(1) - nr) : CNT'(cnt_w - nr + nw);
      ovf_q <= ~ovf_d;
    end
  end
endmodule
